// File: rtl/mem_stage.sv
// Memory stage of the CPU pipeline: holds the instruction issued by pre-memory,
// waits for the DCache response of loads/stores, aligns and merges load data,
// forwards results to the bypass network and drops responses of flushed requests.

package mem_stage_pkg;

  typedef struct packed {
    logic       ex;
    logic [4:0] excode;
  } exception_t;

  typedef struct packed {
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        res_to_mem;
    logic        rf_we;
    logic [31:0] mem_addr;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    exception_t  exception;
    logic [2:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [3:0]  tlb_op;
    logic [4:0]  cache_op;
  } pms_to_ms_bus_t;

  typedef struct packed {
    logic [3:0]  rf_wen;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    exception_t  exception;
    logic [2:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [3:0]  tlb_op;
    logic [4:0]  cache_op;
  } ms_to_ws_bus_t;

  localparam logic [2:0] LOP_LW  = 3'd0;
  localparam logic [2:0] LOP_LB  = 3'd1;
  localparam logic [2:0] LOP_LBU = 3'd2;
  localparam logic [2:0] LOP_LH  = 3'd3;
  localparam logic [2:0] LOP_LHU = 3'd4;
  localparam logic [2:0] LOP_LWL = 3'd5;
  localparam logic [2:0] LOP_LWR = 3'd6;

endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           pms_to_valid,
  output logic           ms_allowin,
  input  logic           ws_allowin,
  output logic           ms_to_valid,
  input  pms_to_ms_bus_t pms_to_ms_bus,
  output ms_to_ws_bus_t  ms_to_ws_bus,
  input  logic           pipeline_flush,
  input  logic           dcache_req_fire,
  input  logic           dcache_data_ok,
  input  logic [31:0]    dcache_rdata,
  output logic [4:0]     fwd_dest,
  output logic [31:0]    fwd_result,
  output logic           fwd_pending
);

  logic           r_ms_valid;
  pms_to_ms_bus_t r_bus;
  logic           r_buf_valid;
  logic [31:0]    r_data_buf;
  logic [1:0]     r_outst;
  logic [1:0]     r_disc;

  logic           w_mem_inst;
  logic           w_need_data;
  logic           w_deliver;
  logic           w_ready_go;
  logic           w_leave;
  logic [1:0]     w_outst_nxt;
  logic [1:0]     w_disc_nxt;
  logic [31:0]    w_rd;
  logic [1:0]     w_off;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load_val;
  logic [3:0]     w_byte_mask;
  logic [31:0]    w_merged;
  logic [31:0]    w_final_result;
  logic [3:0]     w_rf_wen;

  // A response is only handed to the instruction once all flushed requests are drained.
  assign w_mem_inst  = r_bus.res_from_mem | r_bus.res_to_mem;
  assign w_need_data = r_ms_valid & w_mem_inst & ~r_bus.exception.ex;
  assign w_deliver   = dcache_data_ok & (r_disc == 2'd0);
  assign w_ready_go  = ~w_need_data | r_buf_valid | w_deliver;
  assign ms_allowin  = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_valid = r_ms_valid & w_ready_go;
  assign w_leave     = ms_to_valid & ws_allowin;
  assign fwd_pending = w_need_data & ~w_ready_go;

  // Next values of the outstanding-request and discard counters.
  always_comb begin
    w_outst_nxt = r_outst;
    w_disc_nxt  = r_disc;
    case ({dcache_req_fire, dcache_data_ok})
      2'b10: begin
        if (r_outst != 2'd2) begin
          w_outst_nxt = r_outst + 2'd1;
        end else begin
          w_outst_nxt = r_outst;
        end
      end
      2'b01: begin
        if (r_outst != 2'd0) begin
          w_outst_nxt = r_outst - 2'd1;
        end else begin
          w_outst_nxt = r_outst;
        end
      end
      default: w_outst_nxt = r_outst;
    endcase
    // On flush every request still in flight (after this cycle's traffic) is stale.
    if (pipeline_flush) begin
      w_disc_nxt = w_outst_nxt;
    end else if (dcache_data_ok && (r_disc != 2'd0)) begin
      w_disc_nxt = r_disc - 2'd1;
    end else begin
      w_disc_nxt = r_disc;
    end
  end

  // Load data alignment, extension and LWL/LWR byte merge with rt.
  always_comb begin
    w_rd        = r_buf_valid ? r_data_buf : dcache_rdata;
    w_off       = r_bus.mem_addr[1:0];
    w_byte      = w_rd[{w_off, 3'b000} +: 8];
    w_half      = w_rd[{w_off[1], 4'b0000} +: 16];
    w_load_val  = w_rd;
    w_byte_mask = 4'b1111;
    case (r_bus.load_op)
      LOP_LB:  w_load_val = {{24{w_byte[7]}}, w_byte};
      LOP_LBU: w_load_val = {24'h000000, w_byte};
      LOP_LH:  w_load_val = {{16{w_half[15]}}, w_half};
      LOP_LHU: w_load_val = {16'h0000, w_half};
      LOP_LWL: begin
        w_load_val  = w_rd << {(2'd3 - w_off), 3'b000};
        w_byte_mask = 4'b1111 << (2'd3 - w_off);
      end
      LOP_LWR: begin
        w_load_val  = w_rd >> {w_off, 3'b000};
        w_byte_mask = 4'b1111 >> w_off;
      end
      default: w_load_val = w_rd;
    endcase
    w_merged = r_bus.result;
    for (int i = 0; i < 4; i++) begin
      if (w_byte_mask[i]) begin
        w_merged[8*i +: 8] = w_load_val[8*i +: 8];
      end else begin
        w_merged[8*i +: 8] = r_bus.result[8*i +: 8];
      end
    end
    if (r_bus.exception.ex) begin
      w_rf_wen = 4'b0000;
    end else if (r_bus.res_from_mem) begin
      w_rf_wen = w_byte_mask & {4{r_bus.rf_we}};
    end else begin
      w_rf_wen = {4{r_bus.rf_we}};
    end
    w_final_result = r_bus.res_from_mem ? w_merged : r_bus.result;
  end

  // Assemble the write-back bus and the bypass outputs.
  always_comb begin
    ms_to_ws_bus.rf_wen       = w_rf_wen;
    ms_to_ws_bus.dest         = r_bus.dest;
    ms_to_ws_bus.final_result = w_final_result;
    ms_to_ws_bus.pc           = r_bus.pc;
    ms_to_ws_bus.exception    = r_bus.exception;
    ms_to_ws_bus.c0_op        = r_bus.c0_op;
    ms_to_ws_bus.c0_addr      = r_bus.c0_addr;
    ms_to_ws_bus.tlb_op       = r_bus.tlb_op;
    ms_to_ws_bus.cache_op     = r_bus.cache_op;
    if (r_ms_valid && r_bus.rf_we && !r_bus.exception.ex) begin
      fwd_dest = r_bus.dest;
    end else begin
      fwd_dest = 5'd0;
    end
    fwd_result = w_final_result;
  end

  // Stage valid bit and instruction bus register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (pipeline_flush) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= pms_to_valid;
      end
      if (pms_to_valid && ms_allowin) begin
        r_bus <= pms_to_ms_bus;
      end
    end
  end

  // Hold returned load data while write-back is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_data_buf  <= 32'h0000_0000;
    end else if (pipeline_flush || w_leave) begin
      r_buf_valid <= 1'b0;
    end else if (w_deliver && w_need_data && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_data_buf  <= dcache_rdata;
    end
  end

  // Outstanding and discard counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outst <= 2'd0;
      r_disc  <= 2'd0;
    end else begin
      r_outst <= w_outst_nxt;
      r_disc  <= w_disc_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: load latency, alignment, LWL/LWR merge,
// write-back stall buffering, flush discard and exception pass-through.

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic           clk;
  logic           reset;
  logic           pms_to_valid;
  logic           ms_allowin;
  logic           ws_allowin;
  logic           ms_to_valid;
  pms_to_ms_bus_t pms_to_ms_bus;
  ms_to_ws_bus_t  ms_to_ws_bus;
  logic           pipeline_flush;
  logic           dcache_req_fire;
  logic           dcache_data_ok;
  logic [31:0]    dcache_rdata;
  logic [4:0]     fwd_dest;
  logic [31:0]    fwd_result;
  logic           fwd_pending;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pms_to_valid    (pms_to_valid),
    .ms_allowin      (ms_allowin),
    .ws_allowin      (ws_allowin),
    .ms_to_valid     (ms_to_valid),
    .pms_to_ms_bus   (pms_to_ms_bus),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .pipeline_flush  (pipeline_flush),
    .dcache_req_fire (dcache_req_fire),
    .dcache_data_ok  (dcache_data_ok),
    .dcache_rdata    (dcache_rdata),
    .fwd_dest        (fwd_dest),
    .fwd_result      (fwd_result),
    .fwd_pending     (fwd_pending)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pms_to_ms_bus_t mk_bus(input logic [2:0] lop, input logic from_mem,
                                            input logic [31:0] addr, input logic [4:0] dest,
                                            input logic [31:0] rt, input logic ex);
    pms_to_ms_bus_t b;
    b = '0;
    b.load_op      = lop;
    b.res_from_mem = from_mem;
    b.rf_we        = 1'b1;
    b.mem_addr     = addr;
    b.dest         = dest;
    b.result       = rt;
    b.pc           = 32'hBFC0_0000 + addr;
    b.exception.ex = ex;
    return b;
  endfunction

  // Present one instruction from pre-memory for one cycle.
  task automatic issue(input pms_to_ms_bus_t b, input logic fire);
    pms_to_valid    = 1'b1;
    pms_to_ms_bus   = b;
    dcache_req_fire = fire;
    tick();
    pms_to_valid    = 1'b0;
    dcache_req_fire = 1'b0;
  endtask

  logic [31:0] lb_exp [4];

  initial begin
    lb_exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    reset           = 1'b1;
    pms_to_valid    = 1'b0;
    ws_allowin      = 1'b1;
    pms_to_ms_bus   = '0;
    pipeline_flush  = 1'b0;
    dcache_req_fire = 1'b0;
    dcache_data_ok  = 1'b0;
    dcache_rdata    = 32'h0000_0000;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    check_val("rst_to_valid", {31'd0, ms_to_valid}, 32'd0);
    check_val("rst_allowin",  {31'd0, ms_allowin},  32'd1);
    check_val("rst_fwd_dest", {27'd0, fwd_dest},    32'd0);
    check_val("rst_pending",  {31'd0, fwd_pending}, 32'd0);
    tick();

    // LW at 0x100, data_ok two cycles after entry
    issue(mk_bus(LOP_LW, 1'b1, 32'h0000_0100, 5'd7, 32'h0, 1'b0), 1'b1);
    for (int c = 0; c < 2; c++) begin
      #2;
      check_val("lw_wait_pending", {31'd0, fwd_pending}, 32'd1);
      check_val("lw_wait_valid",   {31'd0, ms_to_valid}, 32'd0);
      check_val("lw_wait_dest",    {27'd0, fwd_dest},    32'd7);
      tick();
    end
    dcache_data_ok = 1'b1;
    dcache_rdata   = 32'hDEAD_BEEF;
    #2;
    check_val("lw_valid",   {31'd0, ms_to_valid}, 32'd1);
    check_val("lw_result",  ms_to_ws_bus.final_result, 32'hDEAD_BEEF);
    check_val("lw_fwd",     fwd_result, 32'hDEAD_BEEF);
    check_val("lw_wen",     {28'd0, ms_to_ws_bus.rf_wen}, 32'hF);
    check_val("lw_pending", {31'd0, fwd_pending}, 32'd0);
    tick();
    dcache_data_ok = 1'b0;
    #2;
    check_val("lw_gone", {31'd0, ms_to_valid}, 32'd0);
    tick();

    // LB at each offset
    for (int off = 0; off < 4; off++) begin
      issue(mk_bus(LOP_LB, 1'b1, 32'h0000_0200 + off, 5'd3, 32'h0, 1'b0), 1'b1);
      dcache_data_ok = 1'b1;
      dcache_rdata   = 32'h80FF_7F01;
      #2;
      check_val($sformatf("lb_off%0d", off), ms_to_ws_bus.final_result, lb_exp[off]);
      tick();
      dcache_data_ok = 1'b0;
    end
    // LBU off3
    issue(mk_bus(LOP_LBU, 1'b1, 32'h0000_0203, 5'd3, 32'h0, 1'b0), 1'b1);
    dcache_data_ok = 1'b1;
    #2;
    check_val("lbu_off3", ms_to_ws_bus.final_result, 32'h0000_0080);
    tick();
    dcache_data_ok = 1'b0;
    // LH off2
    issue(mk_bus(LOP_LH, 1'b1, 32'h0000_0202, 5'd3, 32'h0, 1'b0), 1'b1);
    dcache_data_ok = 1'b1;
    #2;
    check_val("lh_off2", ms_to_ws_bus.final_result, 32'hFFFF_80FF);
    check_val("lh_wen",  {28'd0, ms_to_ws_bus.rf_wen}, 32'hF);
    tick();
    dcache_data_ok = 1'b0;

    // LWL off1 / LWR off2 with rt merge
    issue(mk_bus(LOP_LWL, 1'b1, 32'h0000_0301, 5'd4, 32'h1122_3344, 1'b0), 1'b1);
    dcache_data_ok = 1'b1;
    dcache_rdata   = 32'hAABB_CCDD;
    #2;
    check_val("lwl_result", ms_to_ws_bus.final_result, 32'hCCDD_3344);
    check_val("lwl_wen",    {28'd0, ms_to_ws_bus.rf_wen}, 32'hC);
    tick();
    dcache_data_ok = 1'b0;
    issue(mk_bus(LOP_LWR, 1'b1, 32'h0000_0302, 5'd4, 32'h1122_3344, 1'b0), 1'b1);
    dcache_data_ok = 1'b1;
    #2;
    check_val("lwr_result", ms_to_ws_bus.final_result, 32'h1122_AABB);
    check_val("lwr_wen",    {28'd0, ms_to_ws_bus.rf_wen}, 32'h3);
    tick();
    dcache_data_ok = 1'b0;

    // data_ok while write-back stalls for 3 cycles
    ws_allowin = 1'b0;
    issue(mk_bus(LOP_LW, 1'b1, 32'h0000_0104, 5'd8, 32'h0, 1'b0), 1'b1);
    dcache_data_ok = 1'b1;
    dcache_rdata   = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #2;
      check_val("hold_valid",   {31'd0, ms_to_valid}, 32'd1);
      check_val("hold_result",  ms_to_ws_bus.final_result, 32'hCAFE_F00D);
      check_val("hold_allowin", {31'd0, ms_allowin}, 32'd0);
      tick();
      dcache_data_ok = 1'b0;
      dcache_rdata   = 32'h5555_5555;
    end
    ws_allowin = 1'b1;
    #2;
    check_val("hold_rel_valid",   {31'd0, ms_to_valid}, 32'd1);
    check_val("hold_rel_result",  ms_to_ws_bus.final_result, 32'hCAFE_F00D);
    check_val("hold_rel_allowin", {31'd0, ms_allowin}, 32'd1);
    tick();
    #2;
    check_val("hold_gone", {31'd0, ms_to_valid}, 32'd0);
    tick();

    // Two requests in flight, then flush; their responses must be dropped
    issue(mk_bus(LOP_LW, 1'b1, 32'h0000_0400, 5'd9, 32'h0, 1'b0), 1'b1);
    dcache_req_fire = 1'b1;
    tick();
    dcache_req_fire = 1'b0;
    pipeline_flush  = 1'b1;
    tick();
    pipeline_flush  = 1'b0;
    #2;
    check_val("flush_valid",   {31'd0, ms_to_valid}, 32'd0);
    check_val("flush_allowin", {31'd0, ms_allowin},  32'd1);
    issue(mk_bus(LOP_LW, 1'b1, 32'h0000_0404, 5'd10, 32'h0, 1'b0), 1'b0);
    for (int c = 0; c < 2; c++) begin
      dcache_data_ok = 1'b1;
      dcache_rdata   = 32'hBAD0_0000 + c;
      #2;
      check_val($sformatf("drop%0d_valid", c),   {31'd0, ms_to_valid}, 32'd0);
      check_val($sformatf("drop%0d_pending", c), {31'd0, fwd_pending}, 32'd1);
      tick();
    end
    dcache_data_ok  = 1'b0;
    dcache_req_fire = 1'b1;
    #2;
    check_val("after_drop_pending", {31'd0, fwd_pending}, 32'd1);
    tick();
    dcache_req_fire = 1'b0;
    dcache_data_ok  = 1'b1;
    dcache_rdata    = 32'h1234_5678;
    #2;
    check_val("third_valid",  {31'd0, ms_to_valid}, 32'd1);
    check_val("third_result", ms_to_ws_bus.final_result, 32'h1234_5678);
    tick();
    dcache_data_ok = 1'b0;

    // Excepting load passes straight through without waiting
    issue(mk_bus(LOP_LW, 1'b1, 32'h0000_0500, 5'd11, 32'h0, 1'b1), 1'b0);
    #2;
    check_val("ex_valid",   {31'd0, ms_to_valid}, 32'd1);
    check_val("ex_wen",     {28'd0, ms_to_ws_bus.rf_wen}, 32'd0);
    check_val("ex_dest",    {27'd0, fwd_dest}, 32'd0);
    check_val("ex_pending", {31'd0, fwd_pending}, 32'd0);
    tick();
    #2;
    check_val("ex_gone", {31'd0, ms_to_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the CPU pipeline, directly downstream of the pre-memory stage. Holds each instruction issued by pre-memory and, for loads and stores, waits for the DCache `data_ok` response. Aligns and extends load data (including LWL/LWR merge) and forwards results to the bypass network. Tracks outstanding DCache requests so that responses to flushed instructions are silently dropped.

## Interface
- No parameters.
- `clk  in  1  clock`
- `reset  in  1  reset, synchronous, active-high`
- `pms_to_valid  in  1`: pre-memory has a valid instruction ready.
- `ms_allowin  out  1`: memory stage can accept.
- `ws_allowin  in  1`: write-back can accept.
- `ms_to_valid  out  1`: memory stage output valid.
- `pms_to_ms_bus  in  pms_to_ms_bus_t`
  - fields used: `load_op[2:0]`, `res_from_mem`, `res_to_mem`, `rf_we`, `mem_addr[31:0]`, `dest[4:0]`, `result[31:0]` (rt value for loads), `pc`, `exception`, `c0_op`, `c0_addr`, `tlb_op`, `cache_op`.
- `ms_to_ws_bus  out  ms_to_ws_bus_t`
  - carries `rf_wen[3:0]`, `dest`, `final_result[31:0]`, `pc`, `exception`, `c0_op`, `c0_addr`, `tlb_op`, `cache_op`.
- `pipeline_flush  in  1`: exception/ERET flush.
- `dcache_req_fire  in  1`: pre-memory request accepted this cycle (`req && addr_ok`).
- `dcache_data_ok  in  1`: response strobe.
- `dcache_rdata  in  32`: response data.
- `fwd_dest  out  5`: destination register; 0 when not valid or not `rf_we`.
- `fwd_result  out  32`
- `fwd_pending  out  1`: valid load whose data is not yet available.

## Operation
- `load_op` encoding: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved (treat as LW).
- `mem_inst = res_from_mem | res_to_mem`.
- `need_data = ms_valid & mem_inst & !exception.ex`.
- Outstanding counter `outst[1:0]`:
  - +1 on `dcache_req_fire`, −1 on `dcache_data_ok`; both in one cycle leaves it unchanged.
  - Maximum value is 2.
- Discard counter `disc[1:0]`:
  - On `pipeline_flush`, `disc <= outst` next, adjusted for any fire/data_ok in the same cycle.
  - While `disc != 0`, each `data_ok` decrements `disc` and is not delivered.
- Delivery states:
  - **WAIT**: `need_data`, no data yet.
  - **HAVE**: data captured in `data_buf`, `buf_valid = 1`.
  - A delivered `data_ok` with `need_data` and no `buf_valid` captures `dcache_rdata` into `data_buf`.
  - `buf_valid` clears when the instruction leaves or on flush.
- Load alignment, with `off = mem_addr[1:0]`, `rd = buf_valid ? data_buf : dcache_rdata`:
  - LB/LBU: byte `rd[8*off+:8]`, sign- or zero-extended.
  - LH/LHU: halfword `rd[16*off[1]+:16]`, extended.
  - LWL: `rd << 8*(3-off)` merged with `rt` low bytes; `rf_wen = {4'b1111} << (3-off)` masked to 4 bits, i.e. off0 → 1000, off3 → 1111.
  - LWR: `rd >> 8*off`; `rf_wen = 4'b1111 >> off`.
  - All other writes: `rf_wen = {4{rf_we}}`. Merged bytes not enabled come from `rt`.
- `final_result` = aligned load data for loads, otherwise `result`.
- If `exception.ex`, `rf_wen = 0` and no data is awaited.

## Timing
- `ms_ready_go = !need_data | buf_valid | (dcache_data_ok & disc == 0)`.
- `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_valid = ms_valid & ms_ready_go`.
- `ms_valid` update:
  - cleared on reset or flush;
  - otherwise loads `pms_to_valid` when `ms_allowin`.
  - The bus register loads on `pms_to_valid & ms_allowin`.
- Load-use latency: data returned in cycle N is forwarded combinationally in cycle N and leaves the stage at the end of N if `ws_allowin`. If `ws_allowin` is low, data is held in `data_buf`.
- `fwd_pending = need_data & !ms_ready_go`.
- Flush and `data_ok` in the same cycle: that `data_ok` counts as a returned request. `disc` = `outst` − 1 (+1 if fire).
- Reset values:
  - `ms_valid`, `buf_valid`, `outst`, `disc` = 0.
  - Outputs `ms_to_valid = 0`, `fwd_dest = 0`, `fwd_pending = 0`, `ms_allowin = 1`.
- Reset mid-transaction: counters zero. The DCache is reset concurrently, so no stale `data_ok` is expected.

## Test plan
- LW at addr 0x100, `data_ok` 2 cycles after entry with 0xDEADBEEF, `ws_allowin = 1`:
  - `ms_to_valid` high the same cycle as `data_ok`;
  - `final_result = 0xDEADBEEF`, `rf_wen = 1111`;
  - `fwd_pending` high for the 2 waiting cycles.
- LB at offsets 0..3 on rdata 0x80FF7F01 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at off3 → 0x00000080. LH at off2 → 0xFFFF80FF.
- LWL off1 with rt 0x11223344 and rdata 0xAABBCCDD:
  - result 0xCCDD3344, `rf_wen = 1100`.
- LWR off2, same data:
  - result 0x1122AABB, `rf_wen = 0011`.
- `data_ok` arrives while `ws_allowin = 0` for 3 cycles:
  - data held in `data_buf`;
  - output delivered with the correct value when `ws_allowin` rises;
  - no second `data_ok` is required.
- Two requests fired (`outst = 2`), then `pipeline_flush` before any `data_ok`:
  - `disc = 2`; the next two `data_ok` are dropped;
  - a subsequent LW receives the third `data_ok` correctly.
- Instruction with `exception.ex = 1` and `res_from_mem = 1`:
  - passes in 1 cycle without waiting;
  - `rf_wen = 0`, `fwd_dest = 0`.
